// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master system bus arbiter: region codes,
// wait-counter width and FSM state encoding.
package mem_bus_arbiter_pkg;

  localparam int WAIT_W = 4;

  localparam logic [2:0] REG_ROM = 3'd0;
  localparam logic [2:0] REG_RAM = 3'd1;
  localparam logic [2:0] REG_OUT = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational region decoder: addr[13:11] -> one-hot slave enable,
// region wait-state count and unmapped flag.
module mem_region_decode
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic [WAIT_W-1:0] ROM_WAIT = 4'd1,
  parameter logic [WAIT_W-1:0] RAM_WAIT = 4'd0,
  parameter logic [WAIT_W-1:0] OUT_WAIT = 4'd0
) (
  input  logic [2:0]        region,
  output logic [2:0]        en_onehot,
  output logic [WAIT_W-1:0] wait_val,
  output logic              unmapped
);

  // Three populated regions; every other code is a bus error with no wait
  always_comb begin
    en_onehot = 3'b000;
    wait_val  = {WAIT_W{1'b0}};
    unmapped  = 1'b1;
    case (region)
      REG_ROM: begin
        en_onehot = 3'b001;
        wait_val  = ROM_WAIT;
        unmapped  = 1'b0;
      end
      REG_RAM: begin
        en_onehot = 3'b010;
        wait_val  = RAM_WAIT;
        unmapped  = 1'b0;
      end
      REG_OUT: begin
        en_onehot = 3'b100;
        wait_val  = OUT_WAIT;
        unmapped  = 1'b0;
      end
      default: begin
        en_onehot = 3'b000;
        wait_val  = {WAIT_W{1'b0}};
        unmapped  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the shared system bus.
// One transfer at a time: IDLE (grant/latch) -> ACCESS (wait states) -> ACK.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int ROM_WAIT = 1,
  parameter int RAM_WAIT = 0,
  parameter int OUT_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              bus_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic              nce_rom,
  output logic              nce_ram,
  output logic              nce_out
);

  localparam logic [WAIT_W-1:0] WCNT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WCNT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

  state_e              state_r, state_next_s;
  logic                grant_r, rr_last_r, we_r;
  logic [WAIT_W-1:0]   wcnt_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r, m0_rdata_r, m1_rdata_r;
  logic                gnt_valid_s, gnt_s, wcnt_done_s, unmapped_s;
  logic [2:0]          region_s, en_s;
  logic [WAIT_W-1:0]   wait_s;

  assign wcnt_done_s = (wcnt_r == WCNT_ZERO);
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign m0_rdata    = m0_rdata_r;
  assign m1_rdata    = m1_rdata_r;

  // Round-robin pick: on a tie the master not served last wins
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_s       = 1'b0;
    if (m0_req && m1_req) begin
      gnt_valid_s = 1'b1;
      gnt_s       = ~rr_last_r;
    end else if (m0_req) begin
      gnt_valid_s = 1'b1;
      gnt_s       = 1'b0;
    end else if (m1_req) begin
      gnt_valid_s = 1'b1;
      gnt_s       = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_s       = 1'b0;
    end
  end

  // Decode the candidate's address while idle, the latched one during a transfer
  always_comb begin
    region_s = mem_addr_r[13:11];
    if (state_r == ST_IDLE) begin
      region_s = gnt_s ? m1_addr[13:11] : m0_addr[13:11];
    end else begin
      region_s = mem_addr_r[13:11];
    end
  end

  mem_region_decode #(
    .ROM_WAIT (WAIT_W'(ROM_WAIT)),
    .RAM_WAIT (WAIT_W'(RAM_WAIT)),
    .OUT_WAIT (WAIT_W'(OUT_WAIT))
  ) u_decode (
    .region    (region_s),
    .en_onehot (en_s),
    .wait_val  (wait_s),
    .unmapped  (unmapped_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   state_next_s = gnt_valid_s ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_next_s = wcnt_done_s ? ST_ACK : ST_ACCESS;
      ST_ACK:    state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Grant/request latches, wait counter and per-master read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_r     <= 1'b0;
      rr_last_r   <= 1'b1;
      we_r        <= 1'b0;
      wcnt_r      <= WCNT_ZERO;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      m0_rdata_r  <= {DATA_W{1'b0}};
      m1_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            grant_r     <= gnt_s;
            rr_last_r   <= gnt_s;
            we_r        <= gnt_s ? m1_we : m0_we;
            mem_addr_r  <= gnt_s ? m1_addr : m0_addr;
            mem_wdata_r <= gnt_s ? m1_wdata : m0_wdata;
            wcnt_r      <= wait_s;
          end
        end
        ST_ACCESS: begin
          if (!wcnt_done_s) begin
            wcnt_r <= wcnt_r - WCNT_ONE;
          end else if (!we_r) begin
            if (grant_r) m1_rdata_r <= unmapped_s ? {DATA_W{1'b0}} : mem_rdata;
            else         m0_rdata_r <= unmapped_s ? {DATA_W{1'b0}} : mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bus-side strobes and master acks follow the current state only
  always_comb begin
    nce_rom = 1'b1;
    nce_ram = 1'b1;
    nce_out = 1'b1;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    bus_err = 1'b0;
    case (state_r)
      ST_ACCESS: begin
        nce_rom = ~en_s[0];
        nce_ram = ~en_s[1];
        nce_out = ~en_s[2];
        mem_re  = ~we_r & ~unmapped_s;
        mem_we  = we_r & ~unmapped_s & wcnt_done_s;
      end
      ST_ACK: begin
        m0_ack  = ~grant_r;
        m1_ack  = grant_r;
        bus_err = unmapped_s;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter (ROM_WAIT=1, RAM_WAIT=0, OUT_WAIT=0).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        m0_ack, m1_ack, bus_err, mem_re, mem_we, nce_rom, nce_ram, nce_out;
  logic [7:0]  ctl;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign ctl = {nce_rom, nce_ram, nce_out, mem_re, mem_we, m0_ack, m1_ack, bus_err};

  mem_bus_arbiter #(
    .DATA_W(32), .ADDR_W(32), .ROM_WAIT(1), .RAM_WAIT(0), .OUT_WAIT(0)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .bus_err(bus_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .nce_rom(nce_rom), .nce_ram(nce_ram), .nce_out(nce_out)
  );

  // ctl = {nce_rom, nce_ram, nce_out, mem_re, mem_we, m0_ack, m1_ack, bus_err}
  localparam logic [7:0] IDLE_C = 8'hE0;
  localparam logic [7:0] ROM_RD = 8'h70;
  localparam logic [7:0] RAM_RD = 8'hB0;
  localparam logic [7:0] RAM_WR = 8'hA8;
  localparam logic [7:0] OUT_WR = 8'hC8;
  localparam logic [7:0] ACK0   = 8'hE4;
  localparam logic [7:0] ACK1   = 8'hE2;
  localparam logic [7:0] ACK1E  = 8'hE3;

  typedef struct {
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic [31:0] mem_rdata;
    logic [7:0]  exp_ctl;
    logic [31:0] exp_m0_rdata, exp_m1_rdata, exp_addr, exp_wdata;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic m0r, input logic m0w, input logic [31:0] m0a, input logic [31:0] m0d,
    input logic m1r, input logic m1w, input logic [31:0] m1a, input logic [31:0] m1d,
    input logic [31:0] rd, input logic [7:0] c,
    input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] ea, input logic [31:0] ed);
    vec_t v;
    v.m0_req = m0r; v.m0_we = m0w; v.m0_addr = m0a; v.m0_wdata = m0d;
    v.m1_req = m1r; v.m1_we = m1w; v.m1_addr = m1a; v.m1_wdata = m1d;
    v.mem_rdata = rd; v.exp_ctl = c;
    v.exp_m0_rdata = e0; v.exp_m1_rdata = e1; v.exp_addr = ea; v.exp_wdata = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic ack_seen;

    // ROM read (wait 1), latency 3
    vecs[0]  = mk(1'b1,1'b0,32'h4,32'h0,     1'b0,1'b0,32'h0,32'h0,         32'h11223344, IDLE_C, 32'h0,32'h0, 32'h0,32'h0);
    vecs[1]  = mk(1'b1,1'b0,32'h4,32'h0,     1'b0,1'b0,32'h0,32'h0,         32'h11223344, ROM_RD, 32'h0,32'h0, 32'h4,32'h0);
    vecs[2]  = mk(1'b1,1'b0,32'h4,32'h0,     1'b0,1'b0,32'h0,32'h0,         32'h11223344, ROM_RD, 32'h0,32'h0, 32'h4,32'h0);
    vecs[3]  = mk(1'b1,1'b0,32'h4,32'h0,     1'b0,1'b0,32'h0,32'h0,         32'h11223344, ACK0,   32'h11223344,32'h0, 32'h4,32'h0);
    vecs[4]  = mk(1'b0,1'b0,32'h4,32'h0,     1'b0,1'b0,32'h0,32'h0,         32'h11223344, IDLE_C, 32'h11223344,32'h0, 32'h4,32'h0);
    // RAM write by m1; address/data changed after grant must be ignored
    vecs[5]  = mk(1'b0,1'b0,32'h0,32'h0,     1'b1,1'b1,32'h800,32'hDEADBEEF, 32'hFFFFFFFF, IDLE_C, 32'h11223344,32'h0, 32'h4,32'h0);
    vecs[6]  = mk(1'b0,1'b0,32'h0,32'h0,     1'b1,1'b1,32'h0,32'h12345678,   32'hFFFFFFFF, RAM_WR, 32'h11223344,32'h0, 32'h800,32'hDEADBEEF);
    vecs[7]  = mk(1'b0,1'b0,32'h0,32'h0,     1'b1,1'b1,32'h0,32'h12345678,   32'hFFFFFFFF, ACK1,   32'h11223344,32'h0, 32'h800,32'hDEADBEEF);
    vecs[8]  = mk(1'b0,1'b0,32'h0,32'h0,     1'b0,1'b0,32'h0,32'h0,          32'hFFFFFFFF, IDLE_C, 32'h11223344,32'h0, 32'h800,32'hDEADBEEF);
    // Both masters held: m0, m1, m0
    vecs[9]  = mk(1'b1,1'b0,32'h808,32'h0,   1'b1,1'b0,32'h810,32'h0, 32'hA0A0A0A0, IDLE_C, 32'h11223344,32'h0, 32'h800,32'hDEADBEEF);
    vecs[10] = mk(1'b1,1'b0,32'h808,32'h0,   1'b1,1'b0,32'h810,32'h0, 32'hB1B1B1B1, RAM_RD, 32'h11223344,32'h0, 32'h808,32'h0);
    vecs[11] = mk(1'b1,1'b0,32'h808,32'h0,   1'b1,1'b0,32'h810,32'h0, 32'hEEEEEEEE, ACK0,   32'hB1B1B1B1,32'h0, 32'h808,32'h0);
    vecs[12] = mk(1'b1,1'b0,32'h808,32'h0,   1'b1,1'b0,32'h810,32'h0, 32'hEEEEEEEE, IDLE_C, 32'hB1B1B1B1,32'h0, 32'h808,32'h0);
    vecs[13] = mk(1'b1,1'b0,32'h808,32'h0,   1'b1,1'b0,32'h810,32'h0, 32'hC2C2C2C2, RAM_RD, 32'hB1B1B1B1,32'h0, 32'h810,32'h0);
    vecs[14] = mk(1'b1,1'b0,32'h808,32'h0,   1'b1,1'b0,32'h810,32'h0, 32'hEEEEEEEE, ACK1,   32'hB1B1B1B1,32'hC2C2C2C2, 32'h810,32'h0);
    vecs[15] = mk(1'b1,1'b0,32'h808,32'h0,   1'b1,1'b0,32'h810,32'h0, 32'hEEEEEEEE, IDLE_C, 32'hB1B1B1B1,32'hC2C2C2C2, 32'h810,32'h0);
    vecs[16] = mk(1'b1,1'b0,32'h808,32'h0,   1'b1,1'b0,32'h810,32'h0, 32'hD3D3D3D3, RAM_RD, 32'hB1B1B1B1,32'hC2C2C2C2, 32'h808,32'h0);
    vecs[17] = mk(1'b1,1'b0,32'h808,32'h0,   1'b1,1'b0,32'h810,32'h0, 32'hEEEEEEEE, ACK0,   32'hD3D3D3D3,32'hC2C2C2C2, 32'h808,32'h0);
    vecs[18] = mk(1'b0,1'b0,32'h0,32'h0,     1'b0,1'b0,32'h0,32'h0,   32'hEEEEEEEE, IDLE_C, 32'hD3D3D3D3,32'hC2C2C2C2, 32'h808,32'h0);
    // OUT write by m0, request dropped during ACCESS
    vecs[19] = mk(1'b1,1'b1,32'h1000,32'h3FF, 1'b0,1'b0,32'h0,32'h0,  32'hEEEEEEEE, IDLE_C, 32'hD3D3D3D3,32'hC2C2C2C2, 32'h808,32'h0);
    vecs[20] = mk(1'b0,1'b1,32'h1000,32'h3FF, 1'b0,1'b0,32'h0,32'h0,  32'hEEEEEEEE, OUT_WR, 32'hD3D3D3D3,32'hC2C2C2C2, 32'h1000,32'h3FF);
    vecs[21] = mk(1'b0,1'b0,32'h1000,32'h3FF, 1'b0,1'b0,32'h0,32'h0,  32'hEEEEEEEE, ACK0,   32'hD3D3D3D3,32'hC2C2C2C2, 32'h1000,32'h3FF);
    vecs[22] = mk(1'b0,1'b0,32'h0,32'h0,      1'b0,1'b0,32'h0,32'h0,  32'hEEEEEEEE, IDLE_C, 32'hD3D3D3D3,32'hC2C2C2C2, 32'h1000,32'h3FF);
    // Unmapped read by m1
    vecs[23] = mk(1'b0,1'b0,32'h0,32'h0,      1'b1,1'b0,32'h1800,32'h0, 32'h5555AAAA, IDLE_C, 32'hD3D3D3D3,32'hC2C2C2C2, 32'h1000,32'h3FF);
    vecs[24] = mk(1'b0,1'b0,32'h0,32'h0,      1'b1,1'b0,32'h1800,32'h0, 32'h5555AAAA, IDLE_C, 32'hD3D3D3D3,32'hC2C2C2C2, 32'h1800,32'h0);
    vecs[25] = mk(1'b0,1'b0,32'h0,32'h0,      1'b1,1'b0,32'h1800,32'h0, 32'h5555AAAA, ACK1E,  32'hD3D3D3D3,32'h0, 32'h1800,32'h0);
    vecs[26] = mk(1'b0,1'b0,32'h0,32'h0,      1'b0,1'b0,32'h0,32'h0,    32'h5555AAAA, IDLE_C, 32'hD3D3D3D3,32'h0, 32'h1800,32'h0);

    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    mem_rdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("reset ctl", {24'd0, ctl}, {24'd0, IDLE_C});
    check("reset m0_rdata", m0_rdata, 32'h0);
    check("reset m1_rdata", m1_rdata, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      m0_req = vecs[i].m0_req; m0_we = vecs[i].m0_we;
      m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata;
      m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we;
      m1_addr = vecs[i].m1_addr; m1_wdata = vecs[i].m1_wdata;
      mem_rdata = vecs[i].mem_rdata;
      #1;
      check($sformatf("row%0d ctl", i), {24'd0, ctl}, {24'd0, vecs[i].exp_ctl});
      check($sformatf("row%0d m0_rdata", i), m0_rdata, vecs[i].exp_m0_rdata);
      check($sformatf("row%0d m1_rdata", i), m1_rdata, vecs[i].exp_m1_rdata);
      check($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
    end

    // Reset in the middle of a ROM access
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4; mem_rdata = 32'h77777777;
    @(posedge clk);
    #1;
    check("rst pre ctl", {24'd0, ctl}, {24'd0, ROM_RD});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst async ctl", {24'd0, ctl}, {24'd0, IDLE_C});
    check("rst async mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m0_req = 1'b0;
    ack_seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (m0_ack || m1_ack) ack_seen = 1'b1;
    end
    check("rst no ack", {31'd0, ack_seen}, 32'h0);
    check("rst m0_rdata", m0_rdata, 32'h0);

    // Fresh transfer after reset starts from IDLE with normal latency
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h800; mem_rdata = 32'h600DF00D;
    cyc = 0;
    while (!m1_ack && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("post rst latency", cyc, 32'd2);
    check("post rst ack ctl", {24'd0, ctl}, {24'd0, ACK1});
    check("post rst m1_rdata", m1_rdata, 32'h600DF00D);
    m1_req = 1'b0;
    @(posedge clk);
    #1;
    check("post rst idle", {24'd0, ctl}, {24'd0, IDLE_C});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
